// File: rtl/mem_stage_requester.sv
// Memory-stage initiator: decodes icode into one read/write on the req/ack data-memory bus, returns valM.
// Latency: start edge -> mem_req next cycle; ack edge -> done next cycle; non-memory or bad address -> done next cycle.
// Backpressure: mem_req and its address/data are held until mem_ack or timeout; start is ignored while busy.
module mem_stage_requester #(
    parameter logic [63:0] ADDR_LIMIT = 64'd512,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [63:0] valM,
    output logic        busy,
    output logic        done,
    output logic        dmem_error
);

    // Counter must be able to hold TIMEOUT-1; width sized for TIMEOUT itself.
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            w_is_mem;
    logic            w_is_wr;
    logic [63:0]     w_addr;
    logic [63:0]     w_wdata;
    logic            w_addr_bad;
    logic            w_accept;
    logic            w_timeout;

    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [63:0]     r_addr;
    logic [63:0]     r_wdata;
    logic [63:0]     r_valm;
    logic            r_err;

    // Decode icode into transaction kind, address source and write-data source.
    always_comb begin
        w_is_mem = 1'b0;
        w_is_wr  = 1'b0;
        w_addr   = 64'd0;
        w_wdata  = 64'd0;
        case (icode)
            4'h4: begin  // rmmovq: store valA at valE
                w_is_mem = 1'b1;
                w_is_wr  = 1'b1;
                w_addr   = valE;
                w_wdata  = valA;
            end
            4'h5: begin  // mrmovq: load from valE
                w_is_mem = 1'b1;
                w_addr   = valE;
            end
            4'h8: begin  // call: push return address valP at valE
                w_is_mem = 1'b1;
                w_is_wr  = 1'b1;
                w_addr   = valE;
                w_wdata  = valP;
            end
            4'h9: begin  // ret: pop return address from valA
                w_is_mem = 1'b1;
                w_addr   = valA;
            end
            4'hA: begin  // pushq: store valA at valE
                w_is_mem = 1'b1;
                w_is_wr  = 1'b1;
                w_addr   = valE;
                w_wdata  = valA;
            end
            4'hB: begin  // popq: load from valA
                w_is_mem = 1'b1;
                w_addr   = valA;
            end
            default: begin
                w_is_mem = 1'b0;
            end
        endcase
    end

    // Full-width range check and timeout detection shared by FSM and datapath.
    always_comb begin
        w_addr_bad = (w_addr >= ADDR_LIMIT);
        w_accept   = (r_state == S_IDLE) && start;
        w_timeout  = (r_cnt == TO_LAST);
    end

    // State register; async reset drops any in-flight request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: bad addresses and non-memory ops skip REQ; ack beats timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_is_mem && !w_addr_bad) begin
                        w_next = S_REQ;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from the current state.
    always_comb begin
        mem_req = (r_state == S_REQ);
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE);
    end

    // Datapath: latch the transaction on accept, capture read data on ack, track timeout and error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_valm  <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
                if (w_is_mem && !w_addr_bad) begin
                    r_we    <= w_is_wr;
                    r_addr  <= w_addr;
                    r_wdata <= w_wdata;
                    r_err   <= 1'b0;
                end else begin
                    // Out-of-range memory op flags an error; a non-memory op clears it.
                    r_err <= w_is_mem;
                end
            end else if (r_state == S_REQ) begin
                if (mem_ack) begin
                    r_cnt <= '0;
                    if (!r_we) begin
                        r_valm <= mem_rdata;
                    end
                end else if (w_timeout) begin
                    r_cnt <= '0;
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Registered transaction fields drive the bus directly; meaningful only while mem_req.
    always_comb begin
        mem_we     = r_we;
        mem_addr   = r_addr;
        mem_wdata  = r_wdata;
        valM       = r_valm;
        dmem_error = r_err;
    end

endmodule

// File: tb/tb_mem_stage_requester.sv
module tb_mem_stage_requester;

    localparam int          TO  = 16;
    localparam logic [63:0] LIM = 64'd512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [63:0] valA = 64'd0, valE = 64'd0, valP = 64'd0;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = 64'd0;
    logic [63:0] valM;
    logic        busy, done, dmem_error;

    mem_stage_requester #(.ADDR_LIMIT(LIM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .valA(valA), .valE(valE), .valP(valP),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .valM(valM), .busy(busy), .done(done), .dmem_error(dmem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          cycles;
    } req_t;

    typedef struct {
        logic [63:0] valm;
        logic        err;
        int          lat;
    } done_t;

    req_t  exp_req[$];
    done_t exp_done[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    // Reference state: what valM and dmem_error should read after each op.
    logic [63:0] m_valm = 64'd0;
    logic        m_err  = 1'b0;

    // Memory responder configuration for the current op.
    int          cur_delay = 1000;
    logic [63:0] cur_rdata = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Responder: ack on the cur_delay-th request cycle; random junk acks while no request is open.
    int rcnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            rcnt = rcnt + 1;
            mem_ack   = (rcnt == cur_delay);
            mem_rdata = (rcnt == cur_delay) ? cur_rdata : {$urandom, $urandom};
        end else begin
            rcnt = 0;
            mem_ack   = $urandom_range(0, 1) == 1;
            mem_rdata = {$urandom, $urandom};
        end
    end

    // Monitor: pops expectations when the DUT opens a request or pulses done.
    logic prev_req = 1'b0, prev_done = 1'b0;
    req_t cur_req;
    int   req_len = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_req  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_req", 64'd1, 64'd0);
                    cur_req = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, cycles: 0};
                end else begin
                    cur_req = exp_req.pop_front();
                    chk("req_we", {63'd0, mem_we}, {63'd0, cur_req.we});
                    chk("req_addr", mem_addr, cur_req.addr);
                    if (cur_req.we) chk("req_wdata", mem_wdata, cur_req.wdata);
                end
                req_len = 1;
            end else if (mem_req && prev_req) begin
                chk("req_addr_stable", mem_addr, cur_req.addr);
                chk("req_we_stable", {63'd0, mem_we}, {63'd0, cur_req.we});
                if (cur_req.we) chk("req_wdata_stable", mem_wdata, cur_req.wdata);
                req_len++;
            end
            if (!mem_req && prev_req) begin
                chk("req_len", 64'(req_len), 64'(cur_req.cycles));
            end
            if (done) begin
                done_t d;
                chk("done_single_pulse", {63'd0, prev_done}, 64'd0);
                chk("busy_in_done", {63'd0, busy}, 64'd1);
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    d = exp_done.pop_front();
                    chk("valM", valM, d.valm);
                    chk("dmem_error", {63'd0, dmem_error}, {63'd0, d.err});
                    chk("done_latency", 64'(cyc - start_cyc), 64'(d.lat));
                end
            end
            prev_req  = mem_req;
            prev_done = done;
        end
    end

    // Reference model: op table, range check and timeout rule, computed per transaction.
    task automatic model_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                            input logic [63:0] p, input int d, input logic [63:0] rd);
        logic        is_mem, wr;
        logic [63:0] addr, wdata;
        int          n;
        is_mem = 1'b1; wr = 1'b0; addr = e; wdata = 64'd0;
        case (ic)
            4'h4: begin wr = 1'b1; wdata = a; end
            4'h5: ;
            4'h8: begin wr = 1'b1; wdata = p; end
            4'h9: addr = a;
            4'hA: begin wr = 1'b1; wdata = a; end
            4'hB: addr = a;
            default: is_mem = 1'b0;
        endcase
        if (is_mem && addr < LIM) begin
            n = (d <= TO) ? d : TO;
            exp_req.push_back('{we: wr, addr: addr, wdata: wdata, cycles: n});
            if (d <= TO && !wr) m_valm = rd;
            m_err = (d > TO);
            exp_done.push_back('{valm: m_valm, err: m_err, lat: n + 1});
        end else begin
            m_err = is_mem;
            exp_done.push_back('{valm: m_valm, err: m_err, lat: 1});
        end
    endtask

    task automatic do_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, input int d, input logic [63:0] rd);
        int waited;
        model_op(ic, a, e, p, d, rd);
        cur_delay = d;
        cur_rdata = rd;
        @(negedge clk);
        start_cyc = cyc;
        start = 1'b1; icode = ic; valA = a; valE = e; valP = p;
        @(negedge clk);
        // Sometimes poke start again while busy; it must be ignored.
        if ($urandom_range(0, 1) == 1) begin
            start = 1'b1;
            icode = 4'($urandom); valA = {$urandom, $urandom}; valE = 64'($urandom_range(0, 600));
        end else begin
            start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while ((exp_done.size() != 0 || busy) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("op_completed", 64'(exp_done.size() != 0 || busy), 64'd0);
        exp_done.delete();
        exp_req.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ic;
        logic [63:0] a, e, p, rd;
        int          d, sel;

        repeat (3) @(negedge clk);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dmem_error", {63'd0, dmem_error}, 64'd0);
        rst = 1'b0;

        // Directed cases.
        do_op(4'h4, 64'hDEAD, 64'h10, 64'h0, 2, 64'h5555);
        do_op(4'h5, 64'h0, 64'h20, 64'h0, 1, 64'h1234);
        do_op(4'h8, 64'h0, 64'h1F8, 64'h44, 3, 64'h0);
        do_op(4'h9, 64'h1F8, 64'h0, 64'h0, 2, 64'h44);
        do_op(4'hA, 64'h7, 64'h200, 64'h0, 1, 64'h0);
        do_op(4'h5, 64'h0, 64'h1FF, 64'h0, 1, 64'hCAFE);
        do_op(4'h5, 64'h0, 64'h8000_0000_0000_0001, 64'h0, 1, 64'h0);
        do_op(4'hB, 64'h30, 64'h0, 64'h0, 1000, 64'hBAD);
        do_op(4'hB, 64'h30, 64'h0, 64'h0, TO, 64'hF00D);
        do_op(4'hB, 64'h31, 64'h0, 64'h0, TO + 1, 64'hBAD);
        do_op(4'h1, 64'h1, 64'h1, 64'h1, 1, 64'h0);

        // Reset while a request is open.
        model_op(4'hB, 64'h40, 64'h0, 64'h0, 1000, 64'h0);
        cur_delay = 1000;
        @(negedge clk);
        start_cyc = cyc;
        start = 1'b1; icode = 4'hB; valA = 64'h40;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_req_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mid_req_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        exp_req.delete();
        exp_done.delete();
        m_valm = 64'd0;
        m_err  = 1'b0;
        chk("post_rst_valM", valM, 64'd0);
        do_op(4'h0, 64'h0, 64'h0, 64'h0, 1, 64'h0);
        do_op(4'h5, 64'h0, 64'h3, 64'h0, 4, 64'h1111_2222_3333_4444);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            ic  = 4'($urandom);
            if ($urandom_range(0, 3) != 0) ic = 4'($urandom_range(0, 5)) + 4'h4;
            sel = $urandom_range(0, 9);
            if (sel < 7)       begin a = 64'($urandom_range(0, 511)); e = 64'($urandom_range(0, 511)); end
            else if (sel == 7) begin a = 64'd511; e = 64'd512; end
            else if (sel == 8) begin a = 64'd512; e = 64'd511; end
            else               begin a = {$urandom, $urandom}; e = {$urandom, $urandom}; end
            p  = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            d  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(1, 5);
            do_op(ic, a, e, p, d, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
